// File: rtl/ncpu32k_exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates requests, saves PSR/EPC/ELSA,
// restores PSR fields on return, and issues a fetch redirect to the handler.
module ncpu32k_exc_ctrl #(
    parameter logic [31:0] EXC_VEC_BASE = 32'h0000_0100,
    parameter int          PSR_DW       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_ipf,
    input  logic              exc_insn,
    input  logic              exc_dpf,
    input  logic              exc_syscall,
    input  logic              irq,
    input  logic              exc_ret,
    input  logic [31:0]       exc_pc,
    input  logic [31:0]       exc_lsa,
    input  logic [PSR_DW-1:0] msr_psr,
    input  logic [PSR_DW-1:0] msr_epsr,
    input  logic [31:0]       msr_epc,
    output logic              exc_ack,
    output logic              flush,
    output logic              msr_syscall_ent,
    output logic [PSR_DW-1:0] msr_epsr_nxt,
    output logic              msr_epsr_we,
    output logic [31:0]       msr_epc_nxt,
    output logic              msr_epc_we,
    output logic [31:0]       msr_elsa_nxt,
    output logic              msr_elsa_we,
    output logic              msr_psr_cc_nxt,
    output logic              msr_psr_cc_we,
    output logic              msr_psr_rm_nxt,
    output logic              msr_psr_rm_we,
    output logic              msr_psr_ire_nxt,
    output logic              msr_psr_ire_we,
    output logic              msr_psr_imme_nxt,
    output logic              msr_psr_imme_we,
    output logic              msr_psr_dmme_nxt,
    output logic              msr_psr_dmme_we,
    output logic              redirect_vld,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_rdy,
    output logic              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SAVE    = 2'd1;
    localparam logic [1:0] S_RESTORE = 2'd2;
    localparam logic [1:0] S_VECTOR  = 2'd3;

    // Cause codes double as the vector slot index (slot stride 0x10).
    localparam logic [2:0] C_IPF     = 3'd0;
    localparam logic [2:0] C_INSN    = 3'd1;
    localparam logic [2:0] C_DPF     = 3'd2;
    localparam logic [2:0] C_SYSCALL = 3'd3;
    localparam logic [2:0] C_IRQ     = 3'd4;
    localparam logic [2:0] C_RET     = 3'd5;

    localparam int PSR_CC   = 0;
    localparam int PSR_RM   = 4;
    localparam int PSR_IRE  = 5;
    localparam int PSR_IMME = 6;
    localparam int PSR_DMME = 7;

    logic [1:0]  state;
    logic [2:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] lsa_q;
    logic [31:0] tgt_q;
    logic [2:0]  acc_cause;
    logic        req_any;
    logic        accept;
    logic        in_save;
    logic        in_restore;
    logic        in_vector;
    logic        unused_bits;

    always_comb begin
        acc_cause = C_IPF;
        req_any   = 1'b1;
        if (exc_ipf)                       acc_cause = C_IPF;
        else if (exc_insn)                 acc_cause = C_INSN;
        else if (exc_dpf)                  acc_cause = C_DPF;
        else if (exc_syscall)              acc_cause = C_SYSCALL;
        else if (irq && msr_psr[PSR_IRE])  acc_cause = C_IRQ;
        else if (exc_ret)                  acc_cause = C_RET;
        else                               req_any   = 1'b0;
    end

    // Gating with rst keeps the ack low while reset is held.
    assign accept     = req_any && (state == S_IDLE) && !rst;
    assign in_save    = (state == S_SAVE);
    assign in_restore = (state == S_RESTORE);
    assign in_vector  = (state == S_VECTOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept) state <= (acc_cause == C_RET) ? S_RESTORE : S_SAVE;
                S_SAVE:    state <= S_VECTOR;
                S_RESTORE: state <= S_VECTOR;
                S_VECTOR:  if (redirect_rdy) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Data-only registers; every consumer is qualified by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            cause_q <= acc_cause;
            pc_q    <= exc_pc;
            lsa_q   <= exc_lsa;
            tgt_q   <= EXC_VEC_BASE + {25'd0, acc_cause, 4'd0};
        end else if (in_restore) begin
            tgt_q   <= msr_epc;
        end
    end

    assign exc_ack         = accept;
    assign flush           = accept;
    assign busy            = (state != S_IDLE);

    assign msr_syscall_ent = in_save;
    assign msr_epsr_we     = in_save;
    assign msr_epsr_nxt    = in_save ? msr_psr : '0;
    assign msr_epc_we      = in_save;
    // Syscall and irq resume after the current instruction.
    assign msr_epc_nxt     = !in_save ? 32'd0 :
                             ((cause_q == C_SYSCALL) || (cause_q == C_IRQ)) ? pc_q + 32'd4 : pc_q;
    assign msr_elsa_we     = in_save && (cause_q == C_DPF);
    assign msr_elsa_nxt    = msr_elsa_we ? lsa_q : 32'd0;

    assign msr_psr_cc_we    = in_restore;
    assign msr_psr_rm_we    = in_restore;
    assign msr_psr_ire_we   = in_restore;
    assign msr_psr_imme_we  = in_restore;
    assign msr_psr_dmme_we  = in_restore;
    assign msr_psr_cc_nxt   = in_restore && msr_epsr[PSR_CC];
    assign msr_psr_rm_nxt   = in_restore && msr_epsr[PSR_RM];
    assign msr_psr_ire_nxt  = in_restore && msr_epsr[PSR_IRE];
    assign msr_psr_imme_nxt = in_restore && msr_epsr[PSR_IMME];
    assign msr_psr_dmme_nxt = in_restore && msr_epsr[PSR_DMME];

    assign redirect_vld = in_vector;
    assign redirect_pc  = in_vector ? tgt_q : 32'd0;

    assign unused_bits = ^{msr_epsr[PSR_DW-1:8], msr_epsr[3:1]};

endmodule
